// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store size codes (funct3), LSU state type and
// the byte-lane helpers used by the load-store unit.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  // Sizes outside B/H/BU/HU behave as a full word.
  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: return 1'b0;
      LDST_H, LDST_HU: return off[0];
      default:         return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: return 4'b0001 << off;
      LDST_H, LDST_HU: return 4'b0011 << off;
      default:         return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      LDST_B, LDST_BU: return {4{wd[7:0]}};
      LDST_H, LDST_HU: return {2{wd[15:0]}};
      default:         return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data lane select and sign/zero extension of a 32-bit memory word.
// Kept separate so the MMIO read path can share it.
module lsu_load_ext
  import riscv_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rd_i,
  output logic [31:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_lane;

  assign half      = off_i[1] ? rd_i[31:16] : rd_i[15:0];
  assign byte_lane = off_i[0] ? half[15:8] : half[7:0];

  always_comb begin
    case (size_i)
      LDST_B:  data_o = {{24{byte_lane[7]}}, byte_lane};
      LDST_BU: data_o = {24'h0, byte_lane};
      LDST_H:  data_o = {{16{half[15]}}, half};
      LDST_HU: data_o = {16'h0, half};
      default: data_o = rd_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit between the core data port and data memory: stalls the core
// while an access is outstanding, builds byte enables, replicates store data
// and extends load data.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              core_misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  input  logic              mem_ready_i
);

  lsu_state_t        state_q, state_d;
  logic              misaligned;
  logic              load_done;
  logic [DATA_W-1:0] ext_rd;

  assign misaligned = lsu_misaligned(core_size_i, core_addr_i[1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core_req_i && !misaligned) state_d = WAIT;
      WAIT:    if (!core_req_i || mem_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted so an access in flight is
  // dropped in the same cycle reset is seen.
  always_comb begin
    mem_req_o       = 1'b0;
    core_stall_o    = 1'b0;
    core_misalign_o = 1'b0;
    load_done       = 1'b0;
    if (!rst_i && core_req_i) begin
      case (state_q)
        IDLE: begin
          if (misaligned) begin
            core_misalign_o = 1'b1;
          end else begin
            mem_req_o    = 1'b1;
            core_stall_o = 1'b1;
          end
        end
        WAIT: begin
          mem_req_o    = 1'b1;
          core_stall_o = ~mem_ready_i;
          load_done    = mem_ready_i & ~core_we_i;
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o   = mem_req_o & core_we_i;
  assign mem_be_o   = mem_req_o ? lsu_be(core_size_i, core_addr_i[1:0]) : 4'b0000;
  assign mem_wd_o   = mem_req_o ? lsu_wd(core_size_i, core_wd_i) : '0;
  assign mem_addr_o = mem_req_o ? {core_addr_i[ADDR_W-1:2], 2'b00} : '0;
  assign core_rd_o  = load_done ? ext_rd : '0;

  lsu_load_ext u_load_ext (
    .size_i (core_size_i),
    .off_i  (core_addr_i[1:0]),
    .rd_i   (mem_rd_i),
    .data_o (ext_rd)
  );

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vector table, hand-written
// multi-cycle sequences and randomized accesses against a byte-level model.
module tb_riscv_lsu;

  logic        clk_i;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  logic        ready_tied;
  int          checks;
  int          errors;

  riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .core_req_i      (core_req_i),
    .core_we_i       (core_we_i),
    .core_size_i     (core_size_i),
    .core_addr_i     (core_addr_i),
    .core_wd_i       (core_wd_i),
    .core_rd_o       (core_rd_o),
    .core_stall_o    (core_stall_o),
    .core_misalign_o (core_misalign_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wd_o        (mem_wd_o),
    .mem_rd_i        (mem_rd_i),
    .mem_ready_i     (mem_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  a_stall_once: assert property (@(posedge clk_i) disable iff (rst_i || !ready_tied)
      (mem_req_o && core_stall_o) |=> (!core_stall_o && mem_req_o))
    else $error("FAIL stall_once: stall held a second cycle with ready tied high");

  // Reference model: works in bytes per access rather than enable patterns.
  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] s, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int n;
    n = nbytes(s);
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(s);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] s, input logic [31:0] a,
                                       input logic [31:0] mrd);
    longint v;
    longint one;
    int n;
    n   = nbytes(s);
    one = 1;
    v   = longint'(mrd >> (8 * int'(a[1:0])));
    v   = v & ((one << (8 * n)) - 1);
    if ((s == 3'd0 || s == 3'd1) && v >= (one << (8 * n - 1))) v = v - (one << (8 * n));
    return v[31:0];
  endfunction

  task automatic chk(input string nm, input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, tag, act, exp);
    end
  endtask

  task automatic idle(input string nm);
    @(posedge clk_i); #1;
    core_req_i  = 1'b0;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk(nm, "req",   32'(mem_req_o), 32'd0);
    chk(nm, "stall", 32'(core_stall_o), 32'd0);
    chk(nm, "mis",   32'(core_misalign_o), 32'd0);
    chk(nm, "we",    32'(mem_we_o), 32'd0);
    chk(nm, "be",    32'(mem_be_o), 32'd0);
    chk(nm, "wd",    mem_wd_o, 32'd0);
  endtask

  // One access; waits = number of WAIT cycles with mem_ready_i low.
  task automatic access(input string nm, input logic we, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] mrd, input int waits, input logic mis,
                        input logic [3:0] be, input logic [31:0] mwd,
                        input logic [31:0] rd);
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_rd_i    = mrd;
    mem_ready_i = (waits == 0);
    ready_tied  = (waits == 0);
    @(negedge clk_i);
    if (mis) begin
      chk(nm, "mis",   32'(core_misalign_o), 32'd1);
      chk(nm, "req",   32'(mem_req_o), 32'd0);
      chk(nm, "stall", 32'(core_stall_o), 32'd0);
      chk(nm, "be",    32'(mem_be_o), 32'd0);
      return;
    end
    chk(nm, "mis",   32'(core_misalign_o), 32'd0);
    chk(nm, "stall", 32'(core_stall_o), 32'd1);
    chk(nm, "req",   32'(mem_req_o), 32'd1);
    chk(nm, "we",    32'(mem_we_o), 32'(we));
    chk(nm, "be",    32'(mem_be_o), 32'(be));
    chk(nm, "wd",    mem_wd_o, mwd);
    chk(nm, "addr",  mem_addr_o, {addr[31:2], 2'b00});
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk_i); #1;
      mem_ready_i = (i == waits);
      @(negedge clk_i);
      chk(nm, "wreq",   32'(mem_req_o), 32'd1);
      chk(nm, "wstall", 32'(core_stall_o), 32'(i != waits));
      chk(nm, "waddr",  mem_addr_o, {addr[31:2], 2'b00});
      if (i == waits && !we) chk(nm, "rd", core_rd_o, rd);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  vec_t        vecs[14];
  logic        r_we;
  logic [2:0]  r_sz;
  logic [31:0] r_addr, r_wd, r_mrd;
  int          r_waits;
  int          nst, nreq;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    //           we    sz    addr        wd            mrd           mis   be     mwd           rd
    vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80112233, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80112233, 1'b0, 4'h8, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0,        1'b0, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80112233, 1'b0, 4'hC, 32'h0,        32'hFFFF8011};
    vecs[6]  = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h80112233, 1'b0, 4'h3, 32'h0,        32'h00002233};
    vecs[7]  = '{1'b1, 3'd0, 32'h101, 32'h12345678, 32'h0,        1'b0, 4'h2, 32'h78787878, 32'h0};
    vecs[8]  = '{1'b1, 3'd2, 32'h10C, 32'hCAFEF00D, 32'h0,        1'b0, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1'b0, 3'd1, 32'h103, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 3'd3, 32'h104, 32'h0,        32'h11223344, 1'b0, 4'hF, 32'h0,        32'h11223344};
    vecs[11] = '{1'b0, 3'd6, 32'h106, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 1'b0, 4'h2, 32'h0,        32'h0000007F};
    vecs[13] = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h9ABC0000, 1'b0, 4'hC, 32'h0,        32'h00009ABC};

    // Reset with an aligned request pending: every output stays low.
    rst_i       = 1'b1;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h100;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b1;
    ready_tied  = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset", "req",   32'(mem_req_o), 32'd0);
    chk("reset", "stall", 32'(core_stall_o), 32'd0);
    chk("reset", "mis",   32'(core_misalign_o), 32'd0);
    chk("reset", "be",    32'(mem_be_o), 32'd0);
    chk("reset", "rd",    core_rd_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle("post_reset");

    foreach (vecs[v])
      access($sformatf("vec%0d", v), vecs[v].we, vecs[v].sz, vecs[v].addr, vecs[v].wd,
             vecs[v].mrd, 0, vecs[v].mis, vecs[v].be, vecs[v].mwd, vecs[v].rd);
    idle("after_vecs");

    // Three WAIT cycles with ready low: stall covers IDLE plus those three,
    // mem_req additionally covers the completion cycle.
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h300;
    mem_rd_i = 32'h55AA33CC; mem_ready_i = 1'b0; ready_tied = 1'b0;
    nst = 0; nreq = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(posedge clk_i); #1;
        mem_ready_i = (c == 4);
      end
      @(negedge clk_i);
      nst  += int'(core_stall_o);
      nreq += int'(mem_req_o);
      chk("wait3", "addr", mem_addr_o, 32'h300);
      if (c == 4) chk("wait3", "rd", core_rd_o, 32'h55AA33CC);
    end
    idle("wait3_end");
    chk("wait3", "stall_cycles", 32'(nst), 32'd4);
    chk("wait3", "req_cycles",   32'(nreq), 32'd5);

    // Reset pulsed while an access is in WAIT.
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h200;
    mem_ready_i = 1'b0; ready_tied = 1'b0;
    @(negedge clk_i);
    chk("rst_mid", "req0", 32'(mem_req_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid", "req_in_rst",   32'(mem_req_o), 32'd0);
    chk("rst_mid", "stall_in_rst", 32'(core_stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid", "req_after",   32'(mem_req_o), 32'd0);
    chk("rst_mid", "stall_after", 32'(core_stall_o), 32'd0);
    access("rst_sb", 1'b1, 3'd0, 32'h202, 32'h000000A5, 32'h0, 0, 1'b0, 4'h4,
           32'hA5A5A5A5, 32'h0);
    idle("rst_sb_end");

    // Core drops its request in WAIT: memory request ends and the FSM returns to IDLE.
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h400;
    mem_ready_i = 1'b0; ready_tied = 1'b0;
    @(negedge clk_i);
    chk("drop", "stall0", 32'(core_stall_o), 32'd1);
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    @(negedge clk_i);
    chk("drop", "req",   32'(mem_req_o), 32'd0);
    chk("drop", "stall", 32'(core_stall_o), 32'd0);
    access("after_drop", 1'b0, 3'd2, 32'h404, 32'h0, 32'h01020304, 0, 1'b0, 4'hF,
           32'h0, 32'h01020304);
    idle("after_drop_end");

    for (int k = 0; k < 40; k++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_sz    = 3'($urandom_range(0, 7));
      r_addr  = $urandom;
      r_wd    = $urandom;
      r_mrd   = $urandom;
      r_waits = int'($urandom_range(0, 2));
      access($sformatf("rnd%0d", k), r_we, r_sz, r_addr, r_wd, r_mrd, r_waits,
             m_mis(r_sz, r_addr), m_be(r_sz, r_addr), m_wd(r_sz, r_wd),
             m_rd(r_sz, r_addr, r_mrd));
    end
    idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
